// File: rtl/input_pkg.sv
// Shared definitions for the movement event bus: bit map, bus width and the
// per-direction auto-repeat state encoding.
package input_pkg;

  localparam int MV_UP      = 0;
  localparam int MV_LEFT    = 1;
  localparam int MV_RIGHT   = 2;
  localparam int MV_DOWN    = 3;
  localparam int MV_CONFIRM = 4;
  localparam int MV_BACK    = 5;
  localparam int MV_W       = 6;
  localparam int MV_DIRS    = 4;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_FIRST  = 2'd1,
    RPT_HOLD   = 2'd2,
    RPT_REPEAT = 2'd3
  } rpt_state_e;

  // Directions are laid out so that opposing pairs mirror around the middle:
  // up(0)<->down(3), left(1)<->right(2).
  function automatic int opposite_dir(input int dir);
    return MV_DOWN - dir;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button 2-flop synchronizer plus debounce counter; the held level
// toggles only after the synchronized input has differed for DEBOUNCE_CYCLES+1 edges.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_held;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_held  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any cycle of agreement throws away the partial count, so bounces restart it.
      if (r_sync2 == r_held) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_held <= ~r_held;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_held = r_held;

endmodule

// File: rtl/movement_pulse_gen.sv
// Turns raw board buttons into one-cycle movement event pulses with direction
// auto-repeat, opposite-direction lockout, confirm-over-back priority and enable arming.
module movement_pulse_gen
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [MV_W-1:0] btn_raw,
  input  logic            enable,
  output logic [MV_W-1:0] movement,
  output logic [MV_W-1:0] btn_held
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  logic [MV_W-1:0] w_held;
  logic [MV_W-1:0] w_rise;
  logic [MV_W-1:0] w_armed_nxt;
  logic [MV_W-1:0] w_mv_nxt;
  logic [MV_W-1:0] r_held_d;
  logic [MV_W-1:0] r_armed;
  logic [MV_W-1:0] r_movement;

  rpt_state_e       r_state     [MV_DIRS];
  rpt_state_e       w_state_nxt [MV_DIRS];
  logic [CNT_W-1:0] r_cnt       [MV_DIRS];
  logic [CNT_W-1:0] w_cnt_nxt   [MV_DIRS];

  for (genvar g = 0; g < MV_W; g++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .i_raw (btn_raw[g]),
      .o_held(w_held[g])
    );
  end

  always_comb begin
    w_rise      = w_held & ~r_held_d;
    // A bit only re-arms once its button is seen released while enabled.
    w_armed_nxt = enable ? (r_armed | ~w_held) : '0;
    w_mv_nxt    = '0;
    for (int b = 0; b < MV_DIRS; b++) begin
      w_state_nxt[b] = r_state[b];
      w_cnt_nxt[b]   = r_cnt[b];
      if (!enable || !w_held[b]) begin
        w_state_nxt[b] = RPT_IDLE;
        w_cnt_nxt[b]   = '0;
      end else if (w_held[opposite_dir(b)]) begin
        w_state_nxt[b] = RPT_HOLD;
        w_cnt_nxt[b]   = '0;
      end else begin
        case (r_state[b])
          RPT_IDLE: begin
            if (w_rise[b] && r_armed[b]) begin
              w_mv_nxt[b]    = 1'b1;
              w_state_nxt[b] = RPT_FIRST;
              w_cnt_nxt[b]   = DELAY_LOAD;
            end
          end
          RPT_FIRST, RPT_REPEAT: begin
            if (r_cnt[b] == '0) begin
              w_mv_nxt[b]    = 1'b1;
              w_state_nxt[b] = RPT_REPEAT;
              w_cnt_nxt[b]   = PERIOD_LOAD;
            end else begin
              w_cnt_nxt[b] = r_cnt[b] - CNT_W'(1);
            end
          end
          default: begin
            w_state_nxt[b] = RPT_HOLD;
          end
        endcase
      end
    end
    w_mv_nxt[MV_CONFIRM] = enable & w_rise[MV_CONFIRM] & r_armed[MV_CONFIRM];
    w_mv_nxt[MV_BACK]    = enable & w_rise[MV_BACK] & r_armed[MV_BACK] & ~w_mv_nxt[MV_CONFIRM];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held_d   <= '0;
      r_armed    <= '0;
      r_movement <= '0;
      for (int b = 0; b < MV_DIRS; b++) begin
        r_state[b] <= RPT_IDLE;
        r_cnt[b]   <= '0;
      end
    end else begin
      r_held_d   <= w_held;
      r_armed    <= w_armed_nxt;
      r_movement <= w_mv_nxt;
      for (int b = 0; b < MV_DIRS; b++) begin
        r_state[b] <= w_state_nxt[b];
        r_cnt[b]   <= w_cnt_nxt[b];
      end
    end
  end

  assign movement = r_movement;
  assign btn_held = w_held;

endmodule

// File: tb/tb_movement_pulse_gen.sv
// Bench for movement_pulse_gen: directed scenarios with explicit pulse timing plus
// randomized bouncing input checked against a rule-level reference model.
module tb_movement_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] btn_raw;
  logic       enable;
  logic [5:0] movement;
  logic [5:0] btn_held;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  movement_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .enable  (enable),
    .movement(movement),
    .btn_held(btn_held)
  );

  // Reference model: press timestamps and arithmetic on elapsed cycles.
  logic [5:0] raw_q[$];
  logic [5:0] m_held, m_held_d, m_armed, exp_mv;
  int         m_run[6];
  bit         m_active[4];
  bit         m_blocked[4];
  int         m_t0[4];
  int         m_cyc;
  int         opp[4] = '{3, 2, 1, 0};

  task automatic model_reset();
    raw_q    = '{6'd0, 6'd0};
    m_held   = '0;
    m_held_d = '0;
    m_armed  = '0;
    exp_mv   = '0;
    m_cyc    = 0;
    for (int b = 0; b < 6; b++) m_run[b] = 0;
    for (int b = 0; b < 4; b++) begin
      m_active[b] = 0; m_blocked[b] = 0; m_t0[b] = 0;
    end
  endtask

  task automatic model_step();
    logic [5:0] seen, rise, mv;
    int el;
    m_cyc++;
    seen = raw_q.pop_front();
    raw_q.push_back(btn_raw);
    rise = m_held & ~m_held_d;
    mv   = '0;
    for (int b = 0; b < 4; b++) begin
      if (!enable || !m_held[b]) begin
        m_active[b] = 0; m_blocked[b] = 0;
      end else if (m_held[opp[b]]) begin
        m_active[b] = 0; m_blocked[b] = 1;
      end else if (!m_blocked[b]) begin
        if (!m_active[b]) begin
          if (rise[b] && m_armed[b]) begin
            mv[b] = 1'b1; m_active[b] = 1; m_t0[b] = m_cyc;
          end
        end else begin
          el = m_cyc - m_t0[b];
          if (el == RD || (el > RD && (el - RD) % RP == 0)) mv[b] = 1'b1;
        end
      end
    end
    if (enable && rise[4] && m_armed[4]) mv[4] = 1'b1;
    if (enable && rise[5] && m_armed[5] && !mv[4]) mv[5] = 1'b1;
    exp_mv = mv;
    for (int b = 0; b < 6; b++)
      m_armed[b] = !enable ? 1'b0 : (!m_held[b] ? 1'b1 : m_armed[b]);
    m_held_d = m_held;
    // A level is accepted after D+1 consecutive disagreeing samples.
    for (int b = 0; b < 6; b++) begin
      if (seen[b] != m_held[b]) begin
        m_run[b]++;
        if (m_run[b] == D + 1) begin
          m_held[b] = ~m_held[b];
          m_run[b]  = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
  endtask

  task automatic step(input logic [5:0] raw, input logic en);
    @(negedge clk);
    btn_raw = raw;
    enable  = en;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      step(6'b0, 1'b1);
      n_tests++;
      if (movement !== exp_mv || btn_held !== m_held) begin
        n_fail++;
        $display("FAIL settle step %0d: movement=%b btn_held=%b, expected %b %b", i, movement, btn_held, exp_mv, m_held);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_raw = '0; enable = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (movement !== 6'b0 || btn_held !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_values: movement=%b btn_held=%b, expected 000000 000000", movement, btn_held);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(6'b0, 1'b1);
      n_tests++;
      if (movement !== 6'b0 || btn_held !== 6'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle step %0d: movement=%b btn_held=%b, expected 0 0", i, movement, btn_held);
      end
    end
  endtask

  task automatic test_confirm_press();
    int pulses = 0;
    int when = -1;
    for (int i = 0; i < 100; i++) begin
      step(6'b010000, 1'b1);
      n_tests++;
      if (movement !== exp_mv || btn_held !== m_held) begin
        n_fail++;
        $display("FAIL confirm_model step %0d: movement=%b btn_held=%b, expected %b %b", i, movement, btn_held, exp_mv, m_held);
      end
      if (movement !== 6'b0) begin
        pulses++; when = i;
        n_tests++;
        if (movement !== 6'b010000) begin
          n_fail++;
          $display("FAIL confirm_value step %0d: movement=%b, expected 010000", i, movement);
        end
      end
    end
    n_tests++;
    if (pulses != 1 || when != 7) begin
      n_fail++;
      $display("FAIL confirm_timing: %0d pulses last at %0d, expected 1 pulse at 7", pulses, when);
    end
    settle(20);
  endtask

  task automatic test_bounce_repeat();
    int got_q[$];
    int exp_q[$] = '{11, 31, 39, 47};
    logic [5:0] raw;
    for (int i = 0; i < 80; i++) begin
      if (i < 4)       raw = (i % 2 == 0) ? 6'b001000 : 6'b000000;
      else if (i < 48) raw = 6'b001000;
      else             raw = 6'b000000;
      step(raw, 1'b1);
      n_tests++;
      if (movement !== exp_mv || btn_held !== m_held) begin
        n_fail++;
        $display("FAIL bounce_model step %0d: movement=%b btn_held=%b, expected %b %b", i, movement, btn_held, exp_mv, m_held);
      end
      if (movement === 6'b001000) got_q.push_back(i);
      else if (movement !== 6'b0) got_q.push_back(-i);
    end
    n_tests++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL bounce_repeat_times: got %p, expected %p", got_q, exp_q);
    end
    settle(10);
  endtask

  task automatic test_up_down_conflict();
    for (int i = 0; i < 100; i++) begin
      step((i < 60) ? 6'b001001 : 6'b000001, 1'b1);
      n_tests++;
      if (movement[0] !== 1'b0 || movement[3] !== 1'b0 || movement !== exp_mv) begin
        n_fail++;
        $display("FAIL up_down_lockout step %0d: movement=%b, expected %b with bits 0,3 low", i, movement, exp_mv);
      end
    end
    settle(12);
  endtask

  task automatic test_confirm_back();
    int pulses = 0;
    int when = -1;
    for (int i = 0; i < 30; i++) begin
      step(6'b110000, 1'b1);
      n_tests++;
      if (movement[5] !== 1'b0 || movement !== exp_mv) begin
        n_fail++;
        $display("FAIL confirm_back_model step %0d: movement=%b, expected %b", i, movement, exp_mv);
      end
      if (movement === 6'b010000) begin pulses++; when = i; end
    end
    n_tests++;
    if (pulses != 1 || when != 7) begin
      n_fail++;
      $display("FAIL confirm_back_single: %0d confirm pulses last at %0d, expected 1 at 7", pulses, when);
    end
    settle(12);
  endtask

  task automatic test_enable_hold();
    int late = 0;
    int when = -1;
    logic [5:0] raw;
    logic en;
    for (int i = 0; i < 90; i++) begin
      raw = (i < 60 || i >= 70) ? 6'b010000 : 6'b000000;
      en  = (i >= 20 && i < 30) ? 1'b0 : 1'b1;
      step(raw, en);
      n_tests++;
      if (movement !== exp_mv || btn_held !== m_held) begin
        n_fail++;
        $display("FAIL enable_model step %0d: movement=%b btn_held=%b, expected %b %b", i, movement, btn_held, exp_mv, m_held);
      end
      if (i >= 20 && movement !== 6'b0) begin late++; when = i; end
    end
    n_tests++;
    if (late != 1 || when != 77) begin
      n_fail++;
      $display("FAIL enable_rearm: %0d pulses after enable drop last at %0d, expected 1 at 77", late, when);
    end
    settle(12);
  endtask

  task automatic test_reset_mid_repeat();
    int got_q[$];
    int exp_q[$] = '{7, 27, 35};
    for (int i = 0; i < 30; i++) step(6'b001000, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (movement !== 6'b0 || btn_held !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_async: movement=%b btn_held=%b, expected 0 0", movement, btn_held);
    end
    for (int i = 0; i < 3; i++) begin
      step(6'b001000, 1'b1);
      n_tests++;
      if (movement !== 6'b0 || btn_held !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_hold step %0d: movement=%b btn_held=%b, expected 0 0", i, movement, btn_held);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(6'b001000, 1'b1);
      n_tests++;
      if (movement !== exp_mv || btn_held !== m_held) begin
        n_fail++;
        $display("FAIL reset_resume_model step %0d: movement=%b btn_held=%b, expected %b %b", i, movement, btn_held, exp_mv, m_held);
      end
      if (movement !== 6'b0) got_q.push_back(i);
    end
    n_tests++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL reset_resume_times: got %p, expected %p", got_q, exp_q);
    end
    settle(12);
  endtask

  task automatic test_random();
    logic [5:0] target = '0;
    logic [5:0] raw;
    int en_low = 0;
    int pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 6; b++) begin
        if ($urandom_range(0, 39) == 0) target[b] = ~target[b];
        raw[b] = target[b] ^ ($urandom_range(0, 15) == 0);
      end
      if (en_low > 0) en_low--;
      else if ($urandom_range(0, 199) == 0) en_low = $urandom_range(1, 15);
      step(raw, (en_low == 0));
      n_tests++;
      if (movement !== exp_mv || btn_held !== m_held) begin
        n_fail++;
        $display("FAIL random step %0d: movement=%b btn_held=%b, expected %b %b", i, movement, btn_held, exp_mv, m_held);
      end
      if (movement !== 6'b0) pulses++;
    end
    n_tests++;
    if (pulses == 0) begin
      n_fail++;
      $display("FAIL random_activity: %0d pulses seen, expected at least 1", pulses);
    end
    settle(20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_confirm_press();
    test_bounce_repeat();
    test_up_down_conflict();
    test_confirm_back();
    test_enable_hold();
    test_reset_mid_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
